// File: rtl/bp_pkg.sv
// rtl/bp_pkg.sv - shared types and sizing helpers for the branch predictor
package bp_pkg;

    localparam int BP_XLEN    = 32;
    localparam int BP_CNT_MAX = 4;

    // Tag and counter fields are sized for the widest legal configuration;
    // narrower configurations zero-extend into them.
    typedef struct packed {
        logic                  valid;
        logic [BP_XLEN-1:0]    tag;
        logic [BP_XLEN-1:0]    target;
        logic                  isJump;
        logic [BP_CNT_MAX-1:0] counter;
    } bp_entry_t;

    function automatic int idxWidth(input int entries);
        return $clog2(entries);
    endfunction

    function automatic int tagWidth(input int xlen, input int entries);
        return xlen - idxWidth(entries) - 2;
    endfunction

    function automatic logic [BP_CNT_MAX-1:0] cntInit(input int cntBits);
        return BP_CNT_MAX'(1) << (cntBits - 1);
    endfunction

    localparam logic [BP_CNT_MAX-1:0] CNT_INIT = cntInit(2);

endpackage

// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - lookup/update/redirect bundle between core and predictor
interface branch_predictor_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] lookup_pc;
    logic            pred_taken_o;
    logic [XLEN-1:0] pred_target_o;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic            upd_is_jump;
    logic            upd_is_jalr;
    logic            upd_taken;
    logic [XLEN-1:0] upd_target;
    logic            upd_pred_taken;
    logic [XLEN-1:0] upd_pred_target;
    logic            mispredict_o;
    logic [XLEN-1:0] redirect_pc_o;
    logic [31:0]     stat_branches_o;
    logic [31:0]     stat_mispred_o;

    modport master (
        output lookup_pc, upd_valid, upd_pc, upd_is_jump, upd_is_jalr, upd_taken,
               upd_target, upd_pred_taken, upd_pred_target,
        input  pred_taken_o, pred_target_o, mispredict_o, redirect_pc_o,
               stat_branches_o, stat_mispred_o
    );

    modport slave (
        input  lookup_pc, upd_valid, upd_pc, upd_is_jump, upd_is_jalr, upd_taken,
               upd_target, upd_pred_taken, upd_pred_target,
        output pred_taken_o, pred_target_o, mispredict_o, redirect_pc_o,
               stat_branches_o, stat_mispred_o
    );
endinterface

// File: rtl/bp_sat_counter.sv
// rtl/bp_sat_counter.sv - combinational saturating up/down next-value logic
module bp_sat_counter #(
    parameter int CNT_BITS = 2
) (
    input  logic [CNT_BITS-1:0] count,
    input  logic                inc,
    output logic [CNT_BITS-1:0] next
);
    always_comb begin
        next = count;
        if (inc && (count != '1)) begin
            next = count + CNT_BITS'(1);
        end else if (!inc && (count != '0)) begin
            next = count - CNT_BITS'(1);
        end
    end
endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - direct-mapped BTB with saturating counters; BP_STATS_EN adds resolve/mispredict counters
module branch_predictor
    import bp_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ENTRIES  = 16,
    parameter int CNT_BITS = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    branch_predictor_if.slave  bp
);
    localparam int IDX_W = idxWidth(ENTRIES);
    localparam logic [BP_CNT_MAX-1:0] INIT = cntInit(CNT_BITS);

    bp_entry_t btb [ENTRIES];

    logic [IDX_W-1:0]    lkIdx, updIdx;
    logic [BP_XLEN-1:0]  lkTag, updTag;
    bp_entry_t           lkEntry, updEntry;
    logic                lkHit, updHit, lkTaken;
    logic [CNT_BITS-1:0] cntNext;
    logic [XLEN-1:0]     seqNext, actualNext, predNext;
    logic                doUpdate;

    assign lkIdx   = bp.lookup_pc[IDX_W+1:2];
    assign lkTag   = BP_XLEN'(bp.lookup_pc[XLEN-1:IDX_W+2]);
    assign lkEntry = btb[lkIdx];
    assign lkHit   = lkEntry.valid && (lkEntry.tag == lkTag);
    // Any stored counter at or above the weakly-taken value has its MSB set.
    assign lkTaken = lkHit && (lkEntry.isJump || (lkEntry.counter >= INIT));

    assign bp.pred_taken_o  = lkTaken;
    assign bp.pred_target_o = lkTaken ? XLEN'(lkEntry.target) : '0;

    logic unusedPcBits;
    assign unusedPcBits = ^bp.lookup_pc[1:0];

    assign updIdx   = bp.upd_pc[IDX_W+1:2];
    assign updTag   = BP_XLEN'(bp.upd_pc[XLEN-1:IDX_W+2]);
    assign updEntry = btb[updIdx];
    assign updHit   = updEntry.valid && (updEntry.tag == updTag);
    assign doUpdate = bp.upd_valid && !stall && !bp.upd_is_jalr;

    bp_sat_counter #(.CNT_BITS(CNT_BITS)) u_sat_counter (
        .count (updEntry.counter[CNT_BITS-1:0]),
        .inc   (bp.upd_taken),
        .next  (cntNext)
    );

    assign seqNext          = bp.upd_pc + XLEN'(4);
    assign actualNext       = bp.upd_taken ? bp.upd_target : seqNext;
    assign predNext         = bp.upd_pred_taken ? bp.upd_pred_target : seqNext;
    assign bp.mispredict_o  = bp.upd_valid && (actualNext != predNext);
    assign bp.redirect_pc_o = bp.upd_valid ? actualNext : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb[i] <= '0;
            end
        end else if (doUpdate) begin
            if (updHit) begin
                if (bp.upd_is_jump) begin
                    btb[updIdx].target <= BP_XLEN'(bp.upd_target);
                end else begin
                    btb[updIdx].counter <= BP_CNT_MAX'(cntNext);
                    if (bp.upd_taken) begin
                        btb[updIdx].target <= BP_XLEN'(bp.upd_target);
                    end
                end
            end else if (bp.upd_taken) begin
                btb[updIdx] <= '{valid:   1'b1,
                                 tag:     updTag,
                                 target:  BP_XLEN'(bp.upd_target),
                                 isJump:  bp.upd_is_jump,
                                 counter: INIT};
            end
        end
    end

`ifdef BP_STATS_EN
    logic [31:0] statBranches, statMispred;

    always_ff @(posedge clk) begin
        if (rst) begin
            statBranches <= '0;
            statMispred  <= '0;
        end else if (bp.upd_valid && !stall) begin
            if (statBranches != '1) statBranches <= statBranches + 32'd1;
            if (bp.mispredict_o && (statMispred != '1)) statMispred <= statMispred + 32'd1;
        end
    end

    assign bp.stat_branches_o = statBranches;
    assign bp.stat_mispred_o  = statMispred;
`else
    assign bp.stat_branches_o = '0;
    assign bp.stat_mispred_o  = '0;
`endif

endmodule
